// File: rtl/serial_port_ctrl.sv
// Frame-level controller for the serial-to-port demux: parses start/port/length/payload
// and produces the per-bit datapath strobes plus frame bookkeeping registers.
//
// state  | meaning
// IDLE   | waiting for a start bit (serIn=0 on a clkEn edge)
// PORT   | shifting PORT_W port-number bits, MSB first
// LEN    | shifting LEN_W length bits, MSB first; loads remaining-bit count
// DATA   | payload bits, one per clkEn, until remain reaches zero
// DONE   | one-clock completion pulse, then back to IDLE
module serial_port_ctrl #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clkEn,
   input  logic              serIn,
   output logic              shEn,
   output logic              shEnD,
   output logic              ldCntD,
   output logic              cntD,
   output logic              serOutValid,
   output logic              Done,
   output logic [PORT_W-1:0] portNum,
   output logic [LEN_W-1:0]  dataLen,
   output logic              busy
);

   localparam int CNT_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PORT,
      S_LEN,
      S_DATA,
      S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
   logic [LEN_W-1:0]    remain, remain_nxt;
   logic [PORT_W-1:0]   port_nxt, port_shift;
   logic [LEN_W-1:0]    len_nxt, len_shift;

   // Shift-in values; the top bit of the concatenation falls off.
   assign port_shift = PORT_W'({portNum, serIn});
   assign len_shift  = LEN_W'({dataLen, serIn});

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         remain  <= '0;
         portNum <= '0;
         dataLen <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         remain  <= remain_nxt;
         portNum <= port_nxt;
         dataLen <= len_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      remain_nxt  = remain;
      port_nxt    = portNum;
      len_nxt     = dataLen;
      shEn        = 1'b0;
      shEnD       = 1'b0;
      ldCntD      = 1'b0;
      cntD        = 1'b0;
      serOutValid = 1'b0;
      Done        = 1'b0;
      case (state)
         S_IDLE: begin
            if (clkEn && !serIn) begin
               state_nxt   = S_PORT;
               bit_cnt_nxt = '0;
            end
         end
         S_PORT: begin
            if (clkEn) begin
               shEn        = 1'b1;
               port_nxt    = port_shift;
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(PORT_W - 1)) begin
                  state_nxt   = S_LEN;
                  bit_cnt_nxt = '0;
               end
            end
         end
         S_LEN: begin
            if (clkEn) begin
               shEnD       = 1'b1;
               len_nxt     = len_shift;
               bit_cnt_nxt = bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(LEN_W - 1)) begin
                  // Length decided on the last bit itself so payload starts next tick.
                  ldCntD      = 1'b1;
                  remain_nxt  = len_shift;
                  bit_cnt_nxt = '0;
                  state_nxt   = (len_shift == '0) ? S_DONE : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (clkEn) begin
               serOutValid = 1'b1;
               cntD        = 1'b1;
               remain_nxt  = remain - LEN_W'(1);
               if (remain == LEN_W'(1)) state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            Done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Scoreboard bench for serial_port_ctrl: the driver queues the expected strobe set per
// clock, a negedge monitor pops and compares whenever the DUT asserts any strobe.
module tb_serial_port_ctrl;

   localparam int PW = 2;
   localparam int LW = 4;

   localparam logic [5:0] SH = 6'b100000;
   localparam logic [5:0] SD = 6'b010000;
   localparam logic [5:0] LD = 6'b001000;
   localparam logic [5:0] CD = 6'b000110;
   localparam logic [5:0] DN = 6'b000001;

   logic          clk = 1'b0;
   logic          rst, clkEn, serIn;
   logic          shEn, shEnD, ldCntD, cntD, serOutValid, Done, busy;
   logic [PW-1:0] portNum;
   logic [LW-1:0] dataLen;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int            cyc;
      logic [5:0]    v;
      logic [PW-1:0] p;
      logic [LW-1:0] l;
   } exp_t;
   exp_t exq[$];

   serial_port_ctrl #(.PORT_W(PW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .clkEn(clkEn), .serIn(serIn),
      .shEn(shEn), .shEnD(shEnD), .ldCntD(ldCntD), .cntD(cntD),
      .serOutValid(serOutValid), .Done(Done),
      .portNum(portNum), .dataLen(dataLen), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [5:0] v;
      exp_t       e;
      v = {shEn, shEnD, ldCntD, cntD, serOutValid, Done};
      if (v != 6'b0) begin
         checks++;
         if (exq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d got=%b expected none", cyc, v);
         end else begin
            e = exq.pop_front();
            if (e.cyc != cyc || e.v != v) begin
               errors++;
               $display("FAIL strobe cyc=%0d got=%b expected cyc=%0d %b", cyc, v, e.cyc, e.v);
            end
            if (v[0]) begin
               checks++;
               if (portNum != e.p || dataLen != e.l) begin
                  errors++;
                  $display("FAIL frame_regs cyc=%0d got port=%0d len=%0d expected port=%0d len=%0d",
                           cyc, portNum, dataLen, e.p, e.l);
               end
            end
         end
      end
   end

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", n, act, exp);
      end
   endtask

   task automatic tick(input logic ce, input logic si, input logic [5:0] e,
                       input logic [PW-1:0] p, input logic [LW-1:0] l);
      exp_t x;
      clkEn = ce;
      serIn = si;
      if (e != 6'b0) begin
         x.cyc = cyc; x.v = e; x.p = p; x.l = l;
         exq.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   // gap-1 disabled clocks (serIn=0, must be ignored) then one enabled clock.
   task automatic en_tick(input int gap, input logic si, input logic [5:0] e);
      for (int g = 1; g < gap; g++) tick(1'b0, 1'b0, 6'b0, '0, '0);
      tick(1'b1, si, e, '0, '0);
   endtask

   task automatic send_frame(input logic [PW-1:0] p, input logic [LW-1:0] l, input int gap,
                             input logic done_si, input logic [15:0] pay);
      en_tick(gap, 1'b0, 6'b0);
      for (int i = 0; i < PW; i++) en_tick(gap, p[PW-1-i], SH);
      for (int i = 0; i < LW; i++) en_tick(gap, l[LW-1-i], (i == LW-1) ? (SD | LD) : SD);
      for (int k = 0; k < int'(l); k++) en_tick(gap, pay[k], CD);
      tick(gap == 1, done_si, DN, p, l);
   endtask

   task automatic chk_all_zero(input string n);
      chk(n, int'({shEn, shEnD, ldCntD, cntD, serOutValid, Done, busy, portNum, dataLen}), 0);
   endtask

   initial begin
      rst = 1'b1; clkEn = 1'b0; serIn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_all_zero("reset_state");

      // port 2, len 3: shEn 1-2, shEnD 3-6, ldCntD 6, data 7-9, Done 10
      send_frame(2'd2, 4'd3, 1, 1'b1, 16'h0005);
      tick(1'b1, 1'b1, 6'b0, '0, '0);

      // zero-length frame goes straight from LEN to DONE
      send_frame(2'd1, 4'd0, 1, 1'b1, 16'h0000);
      chk("len0_busy_after", int'(busy), 0);
      chk("len0_port", int'(portNum), 1);
      tick(1'b1, 1'b1, 6'b0, '0, '0);

      // same frame as the first with clkEn on every 4th clock
      send_frame(2'd2, 4'd3, 4, 1'b1, 16'h0002);
      tick(1'b1, 1'b1, 6'b0, '0, '0);
      chk("gap_busy_after", int'(busy), 0);

      // reset at tick 8 of the first frame
      tick(1'b1, 1'b0, 6'b0, '0, '0);
      tick(1'b1, 1'b1, SH, '0, '0);
      tick(1'b1, 1'b0, SH, '0, '0);
      tick(1'b1, 1'b0, SD, '0, '0);
      tick(1'b1, 1'b0, SD, '0, '0);
      tick(1'b1, 1'b1, SD, '0, '0);
      tick(1'b1, 1'b1, SD | LD, '0, '0);
      tick(1'b1, 1'b1, CD, '0, '0);
      rst = 1'b1;
      tick(1'b1, 1'b0, CD, '0, '0);
      rst = 1'b0;
      serIn = 1'b1;
      chk_all_zero("midframe_reset");
      tick(1'b1, 1'b1, 6'b0, '0, '0);
      send_frame(2'd1, 4'd2, 1, 1'b1, 16'h0003);
      tick(1'b1, 1'b1, 6'b0, '0, '0);

      // back-to-back: serIn=0 during DONE ignored, next start on the following clock
      send_frame(2'd3, 4'd15, 1, 1'b0, 16'h5A3C);
      send_frame(2'd0, 4'd1, 1, 1'b1, 16'h0001);
      chk("b2b_busy_after", int'(busy), 0);
      chk("b2b_len_after", int'(dataLen), 1);

      repeat (4) tick(1'b1, 1'b1, 6'b0, '0, '0);
      chk("scoreboard_drained", exq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
